// File: rtl/pipe_field_pkg.sv
// Shared constants and types for the FlappyBox obstacle field.
package pipe_field_pkg;

  // game_state encodings from the top-level controller; 2'b00 behaves as idle
  localparam logic [1:0] GsIdle = 2'b01;
  localparam logic [1:0] GsPlay = 2'b10;
  localparam logic [1:0] GsOver = 2'b11;

  // Screen and player sprite geometry
  localparam int unsigned MaxX    = 640;
  localparam int unsigned MaxY    = 480;
  localparam int unsigned TW      = 20;
  localparam int unsigned TH      = 24;
  localparam int unsigned PlayerX = 90;

  // Pipe start-of-game and wrap values
  localparam logic [10:0] RInit0   = 11'd799;
  localparam logic [10:0] RInit1   = 11'd1199;
  localparam logic [10:0] RWrap    = 11'd799;
  localparam logic [8:0]  GapInit0 = 9'd160;
  localparam logic [8:0]  GapInit1 = 9'd200;
  localparam logic [8:0]  GapBase  = 9'd64;
  localparam logic [7:0]  LfsrSeed = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHit
  } state_e;

  function automatic logic gs_is_idle(input logic [1:0] gs);
    return (gs == GsIdle) || (gs == 2'b00);
  endfunction

endpackage

// File: rtl/pipe_field_if.sv
// Pixel-path and game-state bundle between the playfield logic and pipe_field.
interface pipe_field_if;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [1:0]  game_state;
  logic [9:0]  p_x;
  logic [9:0]  p_y;
  logic        pipe_on;
  logic [11:0] rgb_out;
  logic        collide;
  logic [7:0]  score;

  modport master (
    output video_on, x, y, game_state, p_x, p_y,
    input  pipe_on, rgb_out, collide, score
  );

  modport slave (
    input  video_on, x, y, game_state, p_x, p_y,
    output pipe_on, rgb_out, collide, score
  );
endinterface

// File: rtl/gap_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) supplying new gap offsets.
module gap_lfsr
  import pipe_field_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic       fb;

  assign fb = q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3];

  // Free-running shift; only reset re-seeds it
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= LfsrSeed;
    end else begin
      q_q <= {q_q[6:0], fb};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_field.sv
// Two scrolling pipe columns: video overlay, collision and pass scoring.
module pipe_field
  import pipe_field_pkg::*;
#(
  parameter int unsigned MOVE_DIV = 400000,
  parameter int unsigned PIPE_W   = 40,
  parameter int unsigned GAP_H    = 120,
  parameter logic [11:0] PIPE_RGB = 12'h0A0
) (
  input  logic        clk,
  input  logic        reset,
  pipe_field_if.slave bus
);

  localparam int unsigned   CntW    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MOVE_DIV - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [10:0]     r_q   [2];
  logic [8:0]      gap_q [2];
  logic [7:0]      score_q;
  logic            collide_q;
  logic [7:0]      lfsr;

  logic        gs_idle;
  logic        gs_play;
  logic        tick;
  logic        floor_hit;
  logic        hit;
  logic        clear;
  logic [1:0]  x_ov;
  logic [1:0]  y_out;
  logic [1:0]  on;
  logic [1:0]  pass;
  logic [8:0]  score_sum;
  logic [7:0]  score_nx;
  logic [11:0] px_w;
  logic [11:0] py_w;
  logic [11:0] x_w;
  logic [11:0] y_w;

  gap_lfsr u_gap_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr)
  );

  assign gs_idle = gs_is_idle(bus.game_state);
  assign gs_play = (bus.game_state == GsPlay);
  assign px_w    = {2'b00, bus.p_x};
  assign py_w    = {2'b00, bus.p_y};
  assign x_w     = {2'b00, bus.x};
  assign y_w     = {2'b00, bus.y};

  for (genvar i = 0; i < 2; i++) begin : g_pipe
    logic [11:0] r_w;
    logic [11:0] gt_w;
    logic [11:0] gb_w;
    logic        vis;
    logic        in_col;
    logic        in_row;

    assign r_w  = {1'b0, r_q[i]};
    assign gt_w = {3'b000, gap_q[i]};
    assign gb_w = gt_w + 12'(GAP_H - 1);  // last open row

    assign x_ov[i]  = (px_w < r_w) && (r_w <= px_w + 12'(TW - 1 + PIPE_W));
    assign y_out[i] = (py_w < gt_w) || (py_w + 12'(TH - 1) > gb_w);

    // r - PIPE_W < MaxX rewritten to stay unsigned
    assign vis    = (r_q[i] != 11'd0) && (r_w < 12'(MaxX + PIPE_W));
    assign in_col = (x_w + 12'(PIPE_W) >= r_w) && (x_w < r_w);
    assign in_row = (y_w < gt_w) || (y_w > gb_w);
    assign on[i]  = vis && in_col && in_row;

    // Scores on the tick that moves this right edge onto the player's left edge
    assign pass[i] = (r_q[i] == ({1'b0, bus.p_x} + 11'd1));
  end

  assign tick      = (state_q == StRun) && gs_play && (cnt_q == CntLast);
  assign floor_hit = (py_w >= 12'(MaxY - TH));
  assign hit       = floor_hit || |(x_ov & y_out);
  assign clear     = (state_q == StIdle) || gs_idle;

  assign score_sum = {1'b0, score_q} + {8'd0, pass[0]} + {8'd0, pass[1]};
  assign score_nx  = score_sum[8] ? 8'hFF : score_sum[7:0];

  // Game FSM plus replicated pipe datapath; idle request outranks a hit
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      if (reset) begin
        state_q <= StIdle;
      end else begin
        state_q <= ((state_q == StIdle) && gs_play) ? StRun : StIdle;
      end
      cnt_q     <= '0;
      r_q[0]    <= RInit0;
      r_q[1]    <= RInit1;
      gap_q[0]  <= GapInit0;
      gap_q[1]  <= GapInit1;
      score_q   <= 8'd0;
      collide_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hit) begin
            state_q   <= StHit;
            collide_q <= 1'b1;
          end else if (gs_play) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
              for (int i = 0; i < 2; i++) begin
                if (r_q[i] == 11'd0) begin
                  r_q[i]   <= RWrap;
                  gap_q[i] <= GapBase + {1'b0, lfsr};
                end else begin
                  r_q[i] <= r_q[i] - 11'd1;
                end
              end
              score_q <= score_nx;
            end
          end
        end
        StHit: begin
          state_q <= StHit;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.pipe_on = bus.video_on && (state_q != StIdle) && |on;
  assign bus.rgb_out = PIPE_RGB;
  assign bus.collide = collide_q;
  assign bus.score   = score_q;

endmodule
